// File: rtl/mult_pkg.sv
// Shared definitions for the shift/add multiplier controller and its datapath.
package mult_pkg;

  localparam int OPW          = 8;
  localparam int PRODW        = 16;
  localparam int ITW          = 4;
  localparam int MAX_ITER_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // A zero magnitude stays zero under negation, so no negative zero can appear.
  function automatic logic [PRODW-1:0] apply_sign(input logic neg,
                                                  input logic [PRODW-1:0] mag);
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Sequencing FSM for a sign-magnitude shift/add multiplier datapath.
//   state | meaning
//   IDLE  | waiting for start, operands captured on start
//   LOAD  | datapath loads operands and clears its product
//   RUN   | one shift/accumulate per cycle until multiplier exhausted or cap hit
//   FIN   | done pulse, signed result valid
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   a_mc,
  input  logic [OPW-1:0]   b_mp,
  output logic [OPW-1:0]   dp_mc,
  output logic [OPW-1:0]   dp_mp,
  output logic             dp_load,
  output logic             dp_enable,
  output logic             dp_psel,
  output logic             dp_clr,
  input  logic             dp_b0,
  input  logic             dp_zero,
  input  logic [PRODW-1:0] dp_product,
  output logic             busy,
  output logic             done,
  output logic [PRODW-1:0] result
);

  state_t           r_state;
  logic             r_sign;
  logic [ITW-1:0]   r_iter;
  logic             w_last;
  logic             w_step;

  assign w_last = dp_zero || (r_iter == ITW'(MAX_ITER));
  assign w_step = (r_state == S_RUN) && !w_last;

  // Enable and select follow the live multiplier LSB, so they decode combinationally.
  assign dp_enable = w_step;
  assign dp_psel   = w_step & dp_b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sign  <= 1'b0;
      r_iter  <= '0;
      dp_mc   <= '0;
      dp_mp   <= '0;
      dp_load <= 1'b0;
      dp_clr  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      dp_load <= 1'b0;
      dp_clr  <= 1'b0;
      done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            dp_mc   <= a_mc;
            dp_mp   <= b_mp;
            r_sign  <= a_mc[OPW-1] ^ b_mp[OPW-1];
            r_iter  <= '0;
            dp_load <= 1'b1;
            dp_clr  <= 1'b1;
            busy    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: r_state <= S_RUN;
        S_RUN: begin
          if (w_last) begin
            result  <= apply_sign(r_sign, dp_product);
            done    <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_iter <= r_iter + 1'b1;
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: a simple magnitude datapath plus an arithmetic reference model.
module tb_mult_ctrl;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a_mc = '0;
  logic [7:0]  b_mp = '0;
  logic [7:0]  dp_mc, dp_mp;
  logic        dp_load, dp_enable, dp_psel, dp_clr;
  logic        dp_b0, dp_zero;
  logic [15:0] dp_product;
  logic        busy, done;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .a_mc(a_mc), .b_mp(b_mp),
    .dp_mc(dp_mc), .dp_mp(dp_mp), .dp_load(dp_load), .dp_enable(dp_enable),
    .dp_psel(dp_psel), .dp_clr(dp_clr), .dp_b0(dp_b0), .dp_zero(dp_zero),
    .dp_product(dp_product), .busy(busy), .done(done), .result(result)
  );

  // Datapath stand-in; force_nz keeps the exhausted flag low to exercise the iteration cap.
  logic [15:0] r_mc_mag, r_prod;
  logic [7:0]  r_mp_mag;
  bit          force_nz = 1'b0;

  function automatic logic [7:0] mag8(input logic [7:0] v);
    return v[7] ? 8'(-v) : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mc_mag <= '0;
      r_mp_mag <= '0;
      r_prod   <= '0;
    end else begin
      if (dp_load) begin
        r_mc_mag <= {8'h00, mag8(dp_mc)};
        r_mp_mag <= mag8(dp_mp);
      end
      if (dp_clr) r_prod <= '0;
      if (dp_enable) begin
        if (dp_psel) r_prod <= r_prod + r_mc_mag;
        r_mc_mag <= r_mc_mag << 1;
        r_mp_mag <= r_mp_mag >> 1;
      end
    end
  end

  assign dp_b0      = r_mp_mag[0];
  assign dp_zero    = (r_mp_mag == 8'h00) && !force_nz;
  assign dp_product = r_prod;

  // Reference model: an accepted start at edge k with n iterations occupies edges k..k+n+2.
  int          ecnt = 0;
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_n = 0;
  logic [7:0]  m_a = '0, m_b = '0;
  logic [15:0] m_res = '0;

  function automatic int bitlen(input int v);
    int n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin : model
    int bv;
    int p;
    ecnt = ecnt + 1;
    if (rst) begin
      m_active = 1'b0;
      m_res    = '0;
    end else if (start && (!m_active || ecnt >= m_k + m_n + 4)) begin
      m_active = 1'b1;
      m_k      = ecnt;
      m_a      = a_mc;
      m_b      = b_mp;
      bv       = int'($signed(b_mp));
      if (bv < 0) bv = -bv;
      m_n      = force_nz ? MAX_ITER_DEF : bitlen(bv);
    end else if (m_active && ecnt == m_k + m_n + 2) begin
      p     = int'($signed(m_a)) * int'($signed(m_b));
      m_res = 16'(p);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  always @(negedge clk) begin : compare
    int   e;
    int   idx;
    bit   win, en;
    logic [7:0] bmag;
    if (rst) begin
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_done", 16'(done), 16'h0);
      chk("rst_result", result, 16'h0);
      chk("rst_dp_mc", 16'(dp_mc), 16'h0);
      chk("rst_dp_mp", 16'(dp_mp), 16'h0);
      chk("rst_strobes", 16'({dp_load, dp_enable, dp_psel, dp_clr}), 16'h0);
    end else begin
      e    = ecnt;
      win  = m_active && e >= m_k && e <= m_k + m_n + 2;
      en   = m_active && e >= m_k + 1 && e <= m_k + m_n;
      bmag = mag8(m_b);
      idx  = e - m_k - 1;
      chk("busy", 16'(busy), 16'(win));
      chk("done", 16'(done), 16'(m_active && e == m_k + m_n + 2));
      chk("dp_load", 16'(dp_load), 16'(m_active && e == m_k));
      chk("dp_clr", 16'(dp_clr), 16'(m_active && e == m_k));
      chk("dp_enable", 16'(dp_enable), 16'(en));
      chk("dp_psel", 16'(dp_psel), en ? 16'((bmag >> idx) & 8'h01) : 16'h0);
      chk("result", result, m_res);
      if (win) begin
        chk("dp_mc", 16'(dp_mc), 16'(m_a));
        chk("dp_mp", 16'(dp_mp), 16'(m_b));
      end
    end
  end

  // Directed operation with literal expectations; extra_at>0 pulses a stray start mid-operation.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_res, input int exp_lat, input int extra_at);
    int k;
    int t;
    @(negedge clk);
    a_mc  = a;
    b_mp  = b;
    start = 1'b1;
    @(posedge clk);
    #1 k = ecnt;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
      if (t == extra_at) begin
        a_mc  = 8'h11;
        b_mp  = 8'h22;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (t >= 30) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within 30 cycles, expected latency %0d", name, exp_lat);
    end else begin
      chk({name, "_latency"}, 16'(ecnt + 1 - k), 16'(exp_lat));
      chk({name, "_result"}, result, exp_res);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op("s1_5x3",      8'd5,   8'd3,   16'h000F, 5,  0);
    run_op("s2_m5x7",     8'hFB,  8'd7,   16'hFFDD, 6,  0);
    run_op("s3_9x0",      8'd9,   8'd0,   16'h0000, 3,  0);
    run_op("s4_m128sq",   8'h80,  8'h80,  16'h4000, 11, 4);
    run_op("zero_x_m5",   8'd0,   8'hFB,  16'h0000, 6,  0);
    run_op("m1x1",        8'hFF,  8'd1,   16'hFFFF, 4,  0);
    run_op("127xm1",      8'd127, 8'hFF,  16'hFF81, 4,  0);
    run_op("7xm128",      8'd7,   8'h80,  16'hFC80, 11, 0);

    force_nz = 1'b1;
    run_op("cap_3x1",     8'd3,   8'd1,   16'h0003, 11, 0);
    force_nz = 1'b0;
    repeat (2) @(negedge clk);

    // Abort mid-RUN: outputs must clear at once and no done may follow.
    @(negedge clk);
    a_mc  = 8'd5;
    b_mp  = 8'h7F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_result", result, 16'h0);
    chk("abort_done", 16'(done), 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    run_op("s5_2x2",      8'd2,   8'd2,   16'h0004, 5,  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter: MAX_ITER, default 8, maximum number of shift/add iterations before forced completion.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: start  in  1  request a new multiply; sampled only in IDLE.
REQ-005 Port: a_mc  in  8  signed multiplicand operand (two's complement).
REQ-006 Port: b_mp  in  8  signed multiplier operand (two's complement).
REQ-007 Port: dp_mc  out  8  registered multiplicand driven to datapath MC.
REQ-008 Port: dp_mp  out  8  registered multiplier driven to datapath MP.
REQ-009 Port: dp_load  out  1  datapath load strobe.
REQ-010 Port: dp_enable  out  1  datapath shift/accumulate enable.
REQ-011 Port: dp_psel  out  1  datapath accumulate select.
REQ-012 Port: dp_clr  out  1  datapath product clear strobe.
REQ-013 Port: dp_b0  in  1  datapath multiplier LSB.
REQ-014 Port: dp_zero  in  1  datapath multiplier-exhausted flag.
REQ-015 Port: dp_product  in  16  unsigned magnitude product from datapath.
REQ-016 Port: busy  out  1  high in LOAD, RUN and FIN.
REQ-017 Port: done  out  1  one-cycle completion pulse.
REQ-018 Port: result  out  16  signed product, valid when done=1, held until next completion.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, RUN and FIN.
REQ-020 IDLE: start=1 at an edge SHALL capture a_mc->dp_mc, b_mp->dp_mp, sign_q=a_mc[7]^b_mp[7], clear iter count, and go to LOAD.
REQ-021 IDLE: start=0 SHALL hold IDLE.
REQ-022 LOAD (exactly one cycle): dp_load=1 and dp_clr=1; next state SHALL be RUN.
REQ-023 RUN with dp_zero=0 and iter<MAX_ITER: dp_enable=1, dp_psel=dp_b0, iter+1; SHALL stay in RUN.
REQ-024 RUN with dp_zero=1 or iter=MAX_ITER: dp_enable=0; result SHALL be registered as sign_q ? -dp_product : dp_product (16-bit two's complement); next state SHALL be FIN.
REQ-025 FIN (one cycle): done=1; next state SHALL be IDLE.
REQ-026 dp_load, dp_enable, dp_psel and dp_clr SHALL be 0 in every state or condition not listed above.
REQ-027 start while busy=1 SHALL be ignored and not queued.
REQ-028 Latency: with start sampled at edge k and n = bit-length of |b_mp| (0..8), done SHALL be high in cycle k+n+3.
REQ-029 A zero operand SHALL yield result 0 with no negative zero; -128 x -128 SHALL yield 16'h4000.
REQ-030 The iteration counter SHALL be 4 bits wide and SHALL saturate at MAX_ITER, with no wrap.

Reset
REQ-031 rst=1 SHALL force IDLE asynchronously, including mid-operation; the aborted operation SHALL produce no done pulse.
REQ-032 During rst, all outputs SHALL be 0: busy, done, result, dp_mc, dp_mp and all dp_* strobes.
REQ-033 After rst is deasserted, the first start SHALL behave per REQ-020.

Structure
REQ-034 A shared package mult_pkg SHALL hold the state encoding (2-bit enum), OPW=8, PRODW=16 and the MAX_ITER default.
REQ-035 mult_ctrl SHALL contain no sub-module; the datapath is instantiated beside it by the parent top.

Verification
REQ-036 Scenario 1: a_mc=5, b_mp=3, start at edge k -> done at k+5, result=16'h000F.
REQ-037 Scenario 2: a_mc=-5, b_mp=7 -> done at k+6, result=16'hFFDD (-35).
REQ-038 Scenario 3: a_mc=9, b_mp=0 -> done at k+3, result=0, dp_enable never asserted.
REQ-039 Scenario 4: a_mc=-128, b_mp=-128 -> done at k+11, result=16'h4000; a second start pulsed during RUN is ignored.
REQ-040 Scenario 5: rst pulsed mid-RUN -> busy=0 and result=0 immediately, no done pulse; a new start of 2x2 -> result=16'h0004.
